// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the swt16 core, sitting between execute and writeback.
// Non-memory results are registered straight through to writeback. Loads and
// stores are issued to data memory over a req/ack handshake, and upstream is
// held with out_stall while an access is outstanding.
//
// Handshake: in BUSY, dmem_req stays high with stable dmem_we/addr/be/wdata
// until the memory returns dmem_ack; dmem_rdata is sampled in the ack cycle.
// out_stall=1 tells upstream to hold its inputs. A cycle with out_stall=0 and
// in_valid=1 consumes the presented instruction at the next rising edge.
//
// Optional feature, macro MEM_TIMEOUT_EN: an access left unacknowledged for
// TIMEOUT_CYCLES BUSY cycles is discarded and out_bus_error pulses for one
// cycle. Without the macro the stage waits for ack indefinitely.
module mem_stage #(
    parameter int WORD_WIDTH      = 16,
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_act_write_res_to_reg,
    input  logic                       in_act_load,
    input  logic                       in_act_store,
    input  logic                       in_byte,
    input  logic [WORD_WIDTH-1:0]      in_res,
    input  logic [WORD_WIDTH-1:0]      in_store_data,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    output logic                       out_stall,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [1:0]                 dmem_be,
    output logic [WORD_WIDTH-1:0]      dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [WORD_WIDTH-1:0]      dmem_rdata,
    output logic                       out_act_write_res_to_reg,
    output logic [WORD_WIDTH-1:0]      out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_bus_error
);

    localparam int HALF = WORD_WIDTH / 2;

    // Reject configurations the lane logic and timeout counter cannot support.
    if ((WORD_WIDTH % 2) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("mem_stage: WORD_WIDTH must be even and TIMEOUT_CYCLES in 1..65535");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // state_q is the FSM state; checkers can observe it directly.
    state_t                     state_q, state_d;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       bsel_q, bsel_d;
    logic                       byte_q, byte_d;
    logic                       store_q, store_d;
    logic [WORD_WIDTH-1:0]      sdata_q, sdata_d;
    logic [REG_IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                       wr_q, wr_d;
    logic [WORD_WIDTH-1:0]      res_q, res_d;
    logic [REG_IDX_WIDTH-1:0]   ridx_q, ridx_d;
    logic                       stall_c;
    logic                       mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_c;
`endif

    assign mem_op = in_valid & (in_act_load | in_act_store);

    // Next-state, latch and memory-interface decode for the IDLE/BUSY FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bsel_d     = bsel_q;
        byte_d     = byte_q;
        store_d    = store_q;
        sdata_d    = sdata_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        res_d      = res_q;
        ridx_d     = ridx_q;
        stall_c    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 2'b00;
        dmem_wdata = '0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_c  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_c = 1'b1;
                    addr_d  = in_res[DMEM_ADDR_WIDTH:1];
                    bsel_d  = in_res[0];
                    byte_d  = in_byte;
                    // A load wins when both load and store are flagged.
                    store_d = in_act_store & ~in_act_load;
                    sdata_d = in_store_data;
                    idx_d   = in_res_reg_idx;
                    wr_d    = 1'b0;
                    state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    wr_d   = in_valid & in_act_write_res_to_reg;
                    res_d  = in_res;
                    ridx_d = in_res_reg_idx;
                end
            end
            BUSY: begin
                dmem_req  = 1'b1;
                dmem_we   = store_q;
                dmem_addr = addr_q;
                // Word accesses ignore address bit 0: both lanes, no fault.
                dmem_be   = byte_q ? (bsel_q ? 2'b10 : 2'b01) : 2'b11;
                if (store_q) begin
                    dmem_wdata = byte_q ? {2{sdata_q[HALF-1:0]}} : sdata_q;
                end
                stall_c = ~dmem_ack;
                wr_d    = 1'b0;
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!store_q) begin
                        wr_d   = 1'b1;
                        ridx_d = idx_q;
                        if (!byte_q) begin
                            res_d = dmem_rdata;
                        end else if (bsel_q) begin
                            res_d = {{HALF{1'b0}}, dmem_rdata[WORD_WIDTH-1:HALF]};
                        end else begin
                            res_d = {{HALF{1'b0}}, dmem_rdata[HALF-1:0]};
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Give up on the access: the held op is consumed and dropped.
                    state_d   = IDLE;
                    stall_c   = 1'b0;
                    bus_err_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bsel_q  <= 1'b0;
            byte_q  <= 1'b0;
            store_q <= 1'b0;
            sdata_q <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            res_q   <= '0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bsel_q  <= bsel_d;
            byte_q  <= byte_d;
            store_q <= store_d;
            sdata_q <= sdata_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            res_q   <= res_d;
            ridx_q  <= ridx_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // BUSY-cycle counter for the access timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_bus_error = bus_err_c & ~reset;
`else
    assign out_bus_error = 1'b0;
`endif

    // Stall is combinational from the inputs, so force it low while in reset.
    assign out_stall                = stall_c & ~reset;
    assign out_act_write_res_to_reg = wr_q;
    assign out_res                  = res_q;
    assign out_res_reg_idx          = ridx_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_act_write_res_to_reg;
    logic        in_act_load;
    logic        in_act_store;
    logic        in_byte;
    logic [15:0] in_res;
    logic [15:0] in_store_data;
    logic [3:0]  in_res_reg_idx;
    logic        out_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [11:0] dmem_addr;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        out_act_write_res_to_reg;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic        out_bus_error;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(
        .WORD_WIDTH(16),
        .DMEM_ADDR_WIDTH(12),
        .REG_IDX_WIDTH(4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_act_write_res_to_reg(in_act_write_res_to_reg),
        .in_act_load(in_act_load),
        .in_act_store(in_act_store),
        .in_byte(in_byte),
        .in_res(in_res),
        .in_store_data(in_store_data),
        .in_res_reg_idx(in_res_reg_idx),
        .out_stall(out_stall),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .out_act_write_res_to_reg(out_act_write_res_to_reg),
        .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx),
        .out_bus_error(out_bus_error)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid                = 1'b0;
        in_act_write_res_to_reg = 1'b0;
        in_act_load             = 1'b0;
        in_act_store            = 1'b0;
        in_byte                 = 1'b0;
        in_res                  = '0;
        in_store_data           = '0;
        in_res_reg_idx          = '0;
    endtask

    task automatic present(input logic ld, input logic st, input logic by,
                           input logic [15:0] res, input logic [15:0] sd, input logic [3:0] idx);
        drive_idle();
        in_valid       = 1'b1;
        in_act_load    = ld;
        in_act_store   = st;
        in_byte        = by;
        in_res         = res;
        in_store_data  = sd;
        in_res_reg_idx = idx;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int stall_cycles;
    int pulses;

    initial begin
        drive_idle();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        reset      = 1'b1;
        #3;
        check_val("rst_stall", 32'(out_stall), 32'd0);
        check_val("rst_req", 32'(dmem_req), 32'd0);
        check_val("rst_be", 32'(dmem_be), 32'd0);
        check_val("rst_wr", 32'(out_act_write_res_to_reg), 32'd0);
        check_val("rst_res", 32'(out_res), 32'd0);
        check_val("rst_idx", 32'(out_res_reg_idx), 32'd0);
        check_val("rst_buserr", 32'(out_bus_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // ALU pass-through.
        drive_idle();
        in_valid = 1'b1; in_act_write_res_to_reg = 1'b1; in_res = 16'h1234; in_res_reg_idx = 4'd5;
        #1;
        check_val("alu_stall", 32'(out_stall), 32'd0);
        check_val("alu_req", 32'(dmem_req), 32'd0);
        step();
        check_val("alu_res", 32'(out_res), 32'h1234);
        check_val("alu_idx", 32'(out_res_reg_idx), 32'd5);
        check_val("alu_wr", 32'(out_act_write_res_to_reg), 32'd1);

        // Word load at 0x0010, ack after 3 BUSY cycles without ack.
        present(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 4'd3);
        stall_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_stall) stall_cycles++;
            if (c == 1) begin
                check_val("lw_req", 32'(dmem_req), 32'd1);
                check_val("lw_we", 32'(dmem_we), 32'd0);
                check_val("lw_addr", 32'(dmem_addr), 32'd8);
                check_val("lw_be", 32'(dmem_be), 32'b11);
                check_val("lw_bubble", 32'(out_act_write_res_to_reg), 32'd0);
            end
            step();
        end
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        check_val("lw_stall_ack", 32'(out_stall), 32'd0);
        check_val("lw_stall_cycles", 32'(stall_cycles), 32'd4);
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("lw_wr", 32'(out_act_write_res_to_reg), 32'd1);
        check_val("lw_res", 32'(out_res), 32'hBEEF);
        check_val("lw_idx", 32'(out_res_reg_idx), 32'd3);
        check_val("lw_req_after", 32'(dmem_req), 32'd0);

        // Byte load at odd address 0x0011, ack in first BUSY cycle.
        present(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 4'd7);
        #1;
        check_val("lb_stall_pres", 32'(out_stall), 32'd1);
        step();
        dmem_ack = 1'b1; dmem_rdata = 16'hAB12;
        #1;
        check_val("lb_be", 32'(dmem_be), 32'b10);
        check_val("lb_addr", 32'(dmem_addr), 32'd8);
        check_val("lb_stall_ack", 32'(out_stall), 32'd0);
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("lb_res", 32'(out_res), 32'h00AB);
        check_val("lb_wr", 32'(out_act_write_res_to_reg), 32'd1);
        check_val("lb_idx", 32'(out_res_reg_idx), 32'd7);

        // Byte store at 0x0004, data 0x77C3.
        present(1'b0, 1'b1, 1'b1, 16'h0004, 16'h77C3, 4'd9);
        step();
        check_val("sb_bubble", 32'(out_act_write_res_to_reg), 32'd0);
        check_val("sb_req", 32'(dmem_req), 32'd1);
        check_val("sb_we", 32'(dmem_we), 32'd1);
        check_val("sb_be", 32'(dmem_be), 32'b01);
        check_val("sb_wdata", 32'(dmem_wdata), 32'hC3C3);
        check_val("sb_addr", 32'(dmem_addr), 32'd2);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("sb_nowb", 32'(out_act_write_res_to_reg), 32'd0);
        check_val("sb_res_hold", 32'(out_res), 32'h00AB);
        check_val("sb_idx_hold", 32'(out_res_reg_idx), 32'd7);

        // Word store at odd address 0x0007: bit 0 ignored, both lanes.
        present(1'b0, 1'b1, 1'b0, 16'h0007, 16'h5A3C, 4'd1);
        step();
        check_val("sw_addr", 32'(dmem_addr), 32'd3);
        check_val("sw_be", 32'(dmem_be), 32'b11);
        check_val("sw_wdata", 32'(dmem_wdata), 32'h5A3C);
        check_val("sw_we", 32'(dmem_we), 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("sw_nowb", 32'(out_act_write_res_to_reg), 32'd0);

        // Load and store both set: treated as a byte load at even address 0x0020.
        present(1'b1, 1'b1, 1'b1, 16'h0020, 16'hFFFF, 4'd12);
        step();
        check_val("ls_we", 32'(dmem_we), 32'd0);
        check_val("ls_be", 32'(dmem_be), 32'b01);
        check_val("ls_addr", 32'(dmem_addr), 32'h10);
        check_val("ls_wdata", 32'(dmem_wdata), 32'h0000);
        dmem_ack = 1'b1; dmem_rdata = 16'hAB12;
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("ls_res", 32'(out_res), 32'h0012);
        check_val("ls_wr", 32'(out_act_write_res_to_reg), 32'd1);
        check_val("ls_idx", 32'(out_res_reg_idx), 32'd12);

        // Invalid ALU op: result passes, write enable stays low.
        in_valid = 1'b0; in_act_write_res_to_reg = 1'b1; in_res = 16'hFFFF; in_res_reg_idx = 4'd2;
        step();
        drive_idle();
        check_val("inv_wr", 32'(out_act_write_res_to_reg), 32'd0);
        check_val("inv_res", 32'(out_res), 32'hFFFF);

        // Ack in IDLE is ignored.
        dmem_ack = 1'b1;
        #1;
        check_val("idle_ack_req", 32'(dmem_req), 32'd0);
        check_val("idle_ack_stall", 32'(out_stall), 32'd0);
        step();
        dmem_ack = 1'b0;
        check_val("idle_ack_wr", 32'(out_act_write_res_to_reg), 32'd0);

        // Reset in the middle of a BUSY load.
        present(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 4'd4);
        step();
        check_val("mrst_req_before", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mrst_req", 32'(dmem_req), 32'd0);
        check_val("mrst_stall", 32'(out_stall), 32'd0);
        check_val("mrst_be", 32'(dmem_be), 32'd0);
        check_val("mrst_res", 32'(out_res), 32'd0);
        check_val("mrst_wr", 32'(out_act_write_res_to_reg), 32'd0);
        drive_idle();
        @(negedge clock);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        step();
        dmem_ack = 1'b0;
        check_val("mrst_idle_req", 32'(dmem_req), 32'd0);
        check_val("mrst_nowb", 32'(out_act_write_res_to_reg), 32'd0);
        check_val("mrst_res_after", 32'(out_res), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Never acknowledged load: one error pulse, op dropped, then ALU op passes.
        present(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 4'd6);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_bus_error) begin
                pulses++;
                check_val("to_stall", 32'(out_stall), 32'd0);
            end
            step();
            if (pulses != 0) drive_idle();
        end
        check_val("to_pulses", 32'(pulses), 32'd1);
        check_val("to_req", 32'(dmem_req), 32'd0);
        check_val("to_nowb", 32'(out_act_write_res_to_reg), 32'd0);
        in_valid = 1'b1; in_act_write_res_to_reg = 1'b1; in_res = 16'hABCD; in_res_reg_idx = 4'd1;
        step();
        drive_idle();
        check_val("to_alu_res", 32'(out_res), 32'hABCD);
        check_val("to_alu_wr", 32'(out_act_write_res_to_reg), 32'd1);
`else
        // Without the timeout the error output never rises, even on a long wait.
        present(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 4'd6);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_bus_error) pulses++;
            step();
        end
        check_val("nto_pulses", 32'(pulses), 32'd0);
        check_val("nto_still_busy", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 16'h2468;
        step();
        dmem_ack = 1'b0; drive_idle();
        check_val("nto_res", 32'(out_res), 32'h2468);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
